axi4l_gpio_in: RTL

//  AXI4-Lite responder for board inputs (sw[3:0], btn[3:0] on arty-a7-100); the input counterpart of the LED output slave.

---
 rtl/axi4l_gpio_pkg.sv | 35 +++
 rtl/axi4l_if.sv | 36 +++
 rtl/axi4l_gpio_in_debounce.sv | 54 +++++
 rtl/axi4l_gpio_in.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/axi4l_gpio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi4l_gpio_pkg
//  Description : Register offsets, response codes and FSM state types for
//                the AXI4-Lite GPIO input block.
//  Revision    : 1.0
// ============================================================================
package axi4l_gpio_pkg;

    localparam logic [11:0] GPIO_DATA   = 12'h000;
    localparam logic [11:0] GPIO_RISE   = 12'h004;
    localparam logic [11:0] GPIO_FALL   = 12'h008;
    localparam logic [11:0] GPIO_IRQ_EN = 12'h00C;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wstate_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rstate_e;

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4l_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi4l_if
//  Description : 32-bit AXI4-Lite bus bundle with responder/requester views.
//  Revision    : 1.0
// ============================================================================
interface axi4l_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/axi4l_gpio_in_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_debounce
//  Description : One-bit 2-flop synchroniser and stability counter with
//                single-cycle rise/fall strobes on debounced level changes.
//  Revision    : 1.0
// ============================================================================
module gpio_debounce #(
    parameter int DEBOUNCE = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);
    localparam int                 c_cnt_w    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE - 1);

    logic               r_meta;
    logic               r_sync;
    logic               r_stable;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_expire;

    // Strobes fire on the same edge that commits the new stable level
    assign w_expire = (r_sync != r_stable) && (r_cnt == c_cnt_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (r_sync == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = w_expire & r_sync;
    assign o_fall   = w_expire & ~r_sync;
endmodule
`default_nettype wire

// File: rtl/axi4l_gpio_in.sv
`default_nettype none
// ============================================================================
//  Module      : axi4l_gpio_in
//  Description : AXI4-Lite responder for debounced board inputs with sticky
//                W1C edge flags and a level interrupt.
//  Revision    : 1.0
// ============================================================================
module axi4l_gpio_in
    import axi4l_gpio_pkg::*;
#(
    parameter int N        = 8,
    parameter int DEBOUNCE = 100000
) (
    input  logic         clk,
    input  logic         rst_n,
    axi4l_if.slave       axi,
    input  logic [N-1:0] gpio_in,
    output logic         irq
);
    logic [N-1:0] w_stable, w_rise, w_fall;
    logic [N-1:0] r_rise, r_fall, r_irq_en;
    logic         r_irq;

    wstate_e      r_wstate;
    rstate_e      r_rstate;
    logic         r_awready, r_bvalid, r_arready, r_rvalid;
    resp_t        r_bresp, r_rresp;
    logic [31:0]  r_rdata;

    logic [31:0]  w_mask32;
    logic [N-1:0] w_mask, w_wbits;
    logic [N-1:0] w_rise_clr, w_fall_clr, w_en_next;
    logic         w_wr_fire;
    resp_t        w_wr_resp, w_rd_resp;
    logic [31:0]  w_rd_data;
    logic         w_unused;

    generate
        for (genvar i = 0; i < N; i++) begin : g_bit
            gpio_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_raw    (gpio_in[i]),
                .o_stable (w_stable[i]),
                .o_rise   (w_rise[i]),
                .o_fall   (w_fall[i])
            );
        end
    endgenerate

    assign w_mask32  = strb_to_mask(axi.wstrb);
    assign w_mask    = w_mask32[N-1:0];
    assign w_wbits   = axi.wdata[N-1:0] & w_mask;
    assign w_wr_fire = r_awready && axi.awvalid && axi.wvalid;
    assign w_unused  = ^{axi.awaddr[31:12], axi.araddr[31:12], axi.wdata, w_mask32};

    always_comb begin
        w_rise_clr = '0;
        w_fall_clr = '0;
        w_en_next  = r_irq_en;
        w_wr_resp  = OKAY;
        case (axi.awaddr[11:0])
            GPIO_DATA:   ;
            GPIO_RISE:   if (w_wr_fire) w_rise_clr = w_wbits;
            GPIO_FALL:   if (w_wr_fire) w_fall_clr = w_wbits;
            GPIO_IRQ_EN: if (w_wr_fire) w_en_next = (r_irq_en & ~w_mask) | w_wbits;
            default:     w_wr_resp = SLVERR;
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = OKAY;
        case (axi.araddr[11:0])
            GPIO_DATA:   w_rd_data[N-1:0] = w_stable;
            GPIO_RISE:   w_rd_data[N-1:0] = r_rise;
            GPIO_FALL:   w_rd_data[N-1:0] = r_fall;
            GPIO_IRQ_EN: w_rd_data[N-1:0] = r_irq_en;
            default:     w_rd_resp = SLVERR;
        endcase
    end

    // A new edge in the same cycle as its W1C clear keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise   <= '0;
            r_fall   <= '0;
            r_irq_en <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_rise   <= (r_rise & ~w_rise_clr) | w_rise;
            r_fall   <= (r_fall & ~w_fall_clr) | w_fall;
            r_irq_en <= w_en_next;
            r_irq    <= |((r_rise | r_fall) & r_irq_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (r_awready) begin
                        r_awready <= 1'b0;
                        if (axi.awvalid && axi.wvalid) begin
                            r_bvalid <= 1'b1;
                            r_bresp  <= w_wr_resp;
                            r_wstate <= W_RESP;
                        end
                    end else if (axi.awvalid && axi.wvalid) begin
                        r_awready <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (axi.bready) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (r_arready) begin
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rd_data;
                        r_rresp   <= w_rd_resp;
                        r_rstate  <= R_RESP;
                    end else if (axi.arvalid) begin
                        r_arready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (axi.rready) begin
                        r_rvalid <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
            endcase
        end
    end

    assign axi.awready = r_awready;
    assign axi.wready  = r_awready;
    assign axi.bvalid  = r_bvalid;
    assign axi.bresp   = r_bresp;
    assign axi.arready = r_arready;
    assign axi.rvalid  = r_rvalid;
    assign axi.rdata   = r_rdata;
    assign axi.rresp   = r_rresp;
    assign irq         = r_irq;
endmodule
`default_nettype wire
